axi_read_arbiter: RTL
=====================

// Module: axi_read_arbiter
// PURPOSE
//  Shares one AXI3-style read slave (AR + R channels) between NM read masters.
//  Round-robin arbitration on AR; one burst in flight at a time.
//  R channel routed back to the granted master until RLAST handshake.
//  Sits between the ReadMaster instances and the single ReadSlave.
// PARAMETERS
//  NM        2   number of requesting masters (2..8)
//  buswidth  32  ARADDR / RDATA width
//  tagbits   4   ARID / RID width
// PORTS
//  ACLK        in   1             bus clock, all logic rising-edge
//  ARESET      in   1             async reset, active-high
//  m_ARID      in   NM*tagbits    per-master AR fields, master i at slice i
//  m_ARADDR    in   NM*buswidth   "
//  m_ARLEN     in   NM*4          "
//  m_ARSIZE    in   NM*2          "
//  m_ARBURST   in   NM*2          "
//  m_ARLOCK    in   NM*2          "
//  m_ARCACHE   in   NM*4          "
//  m_ARPROT    in   NM*3          "
//  m_ARVALID   in   NM            per-master request
//  m_ARREADY   out  NM            per-master accept (one-hot or 0)
//  m_RID/m_RDATA/m_RRESP/m_RLAST  out  tagbits/buswidth/2/1  broadcast from slave
//  m_RVALID    out  NM            one-hot to granted master only
//  m_RREADY    in   NM            per-master data ready
//  s_ARID..s_ARPROT  out  as above, single  registered AR payload to slave
//  s_ARVALID   out  1             AR request to slave
//  s_ARREADY   in   1             slave accept
//  s_RID/s_RDATA/s_RRESP/s_RLAST  in  tagbits/buswidth/2/1  slave read data
//  s_RVALID    in   1             slave data valid
//  s_RREADY    out  1             = m_RREADY[grant] in DATA, else 0
//  grant_idx   out  $clog2(NM)    current/last granted master
//  len_err     out  1             sticky burst-length mismatch flag
// BEHAVIOUR
//  Reset (async, ARESET=1): state IDLE; s_ARVALID, m_ARREADY, m_RVALID, s_RREADY,
//   len_err = 0; s_AR* payload = 0; grant_idx = 0; rr pointer = NM-1 (master 0 first).
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if any m_ARVALID, winner = first requester scanning from rr_ptr+1 mod NM;
//   m_ARREADY[winner]=1 combinationally this cycle; payload registered, grant_idx and
//   rr_ptr <= winner, beat counter <= 0, go ADDR. No request: stay, all readies 0.
//  ADDR: s_ARVALID=1, payload stable; on s_ARREADY go DATA. Zero-wait slave -> 1 cycle.
//  DATA: m_RVALID[grant]=s_RVALID, others 0; s_RREADY=m_RREADY[grant]; m_R* fields
//   broadcast. Each R handshake increments 5-bit beat counter.
//   Handshake with s_RLAST=1 -> IDLE. m_ARREADY all 0 in ADDR and DATA.
//  Latency: grant->s_ARVALID 1 cycle; min 1 IDLE cycle between bursts.
//  len_err: set if RLAST on beat != ARLEN+1, or beat ARLEN+1 handshakes without
//   RLAST; sticky until reset; routing unaffected (only RLAST ends a burst).
//  Requester dropping ARVALID before grant: ignored, no grant. Requests arriving in
//   ADDR/DATA wait for IDLE. Simultaneous RLAST and new requests: new grant next cycle.
//  Reset mid-burst: immediate return to IDLE, outstanding beats dropped.
// STRUCTURE
//  axi_read_pkg: buswidth, tagbits defaults; FSM state encodings (IDLE/ADDR/DATA).
//  Sub-module rr_arbiter: combinational round-robin pick (req, ptr -> onehot, idx, any).
// TESTING
//  1 Single req m0, ARLEN=3, slave zero-wait -> m_ARREADY[0] 1 cycle, s_ARVALID next
//    cycle, 4 beats only to m_RVALID[0], back to IDLE after RLAST, len_err=0.
//  2 m0,m1 request continuously, NM=2 -> grants alternate 0,1,0,1 over 4 bursts.
//  3 s_ARREADY held low 5 cycles -> s_ARVALID and payload stable 5 cycles, no R routing.
//  4 m1 drops m_RREADY on beat 2 -> s_RREADY=0 that cycle, beat not counted.
//  5 ARLEN=3, slave RLAST on beat 2 -> len_err=1, stays 1 after next clean burst.
//  6 ARESET asserted mid-DATA -> all valids/readies 0 same cycle; m0 wins next request.

Source files
------------

// File: rtl/axi_read_pkg.sv
// Shared definitions for the AXI read arbiter: default bus widths, FSM
// state encoding and a helper for the expected beat count of a burst.
package axi_read_pkg;

  localparam int BUSWIDTH_DEF = 32;
  localparam int TAGBITS_DEF  = 4;
  localparam int BEAT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // AXI3 ARLEN encodes beats-1; a 4-bit length gives 1..16 beats.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [3:0] arlen);
    return {1'b0, arlen} + 5'd1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the winner is the first asserted
// request found scanning upward from ptr_i+1, wrapping modulo NM.
module rr_arbiter #(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [NM-1:0] onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan candidates from farthest to nearest so the nearest hit wins last.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    any_o    = |req_i;
    for (int k = NM; k >= 1; k--) begin
      int c;
      c = (int'(ptr_i) + k) % NM;
      if (req_i[c]) begin
        idx_o = IW'(c);
      end
    end
    if (any_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read slave between NM masters. Round-robin arbitration on
// AR, one burst in flight, R channel steered to the granted master until the
// RLAST handshake. Beat count is checked against ARLEN into a sticky flag.
module axi_read_arbiter
  import axi_read_pkg::*;
#(
  parameter int NM       = 2,
  parameter int buswidth = BUSWIDTH_DEF,
  parameter int tagbits  = TAGBITS_DEF,
  parameter int GW       = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  // master-side AR
  input  logic [NM*tagbits-1:0]  m_ARID,
  input  logic [NM*buswidth-1:0] m_ARADDR,
  input  logic [NM*4-1:0]        m_ARLEN,
  input  logic [NM*2-1:0]        m_ARSIZE,
  input  logic [NM*2-1:0]        m_ARBURST,
  input  logic [NM*2-1:0]        m_ARLOCK,
  input  logic [NM*4-1:0]        m_ARCACHE,
  input  logic [NM*3-1:0]        m_ARPROT,
  input  logic [NM-1:0]          m_ARVALID,
  output logic [NM-1:0]          m_ARREADY,
  // master-side R
  output logic [tagbits-1:0]     m_RID,
  output logic [buswidth-1:0]    m_RDATA,
  output logic [1:0]             m_RRESP,
  output logic                   m_RLAST,
  output logic [NM-1:0]          m_RVALID,
  input  logic [NM-1:0]          m_RREADY,
  // slave-side AR
  output logic [tagbits-1:0]     s_ARID,
  output logic [buswidth-1:0]    s_ARADDR,
  output logic [3:0]             s_ARLEN,
  output logic [1:0]             s_ARSIZE,
  output logic [1:0]             s_ARBURST,
  output logic [1:0]             s_ARLOCK,
  output logic [3:0]             s_ARCACHE,
  output logic [2:0]             s_ARPROT,
  output logic                   s_ARVALID,
  input  logic                   s_ARREADY,
  // slave-side R
  input  logic [tagbits-1:0]     s_RID,
  input  logic [buswidth-1:0]    s_RDATA,
  input  logic [1:0]             s_RRESP,
  input  logic                   s_RLAST,
  input  logic                   s_RVALID,
  output logic                   s_RREADY,
  // status
  output logic [GW-1:0]          grant_idx,
  output logic                   len_err
);

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                len_err_q, len_err_d;

  logic [tagbits-1:0]  ar_id_q, ar_id_d;
  logic [buswidth-1:0] ar_addr_q, ar_addr_d;
  logic [3:0]          ar_len_q, ar_len_d;
  logic [1:0]          ar_size_q, ar_size_d;
  logic [1:0]          ar_burst_q, ar_burst_d;
  logic [1:0]          ar_lock_q, ar_lock_d;
  logic [3:0]          ar_cache_q, ar_cache_d;
  logic [2:0]          ar_prot_q, ar_prot_d;

  logic [NM-1:0]       win_onehot;
  logic [GW-1:0]       win_idx;
  logic                win_any;
  logic                r_hs;
  logic [BEAT_W-1:0]   beat_n;

  rr_arbiter #(
    .NM (NM),
    .IW (GW)
  ) u_rr (
    .req_i    (m_ARVALID),
    .ptr_i    (rr_ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  // Slave read data is broadcast; only RVALID is steered per master.
  assign m_RID     = s_RID;
  assign m_RDATA   = s_RDATA;
  assign m_RRESP   = s_RRESP;
  assign m_RLAST   = s_RLAST;

  assign s_ARID    = ar_id_q;
  assign s_ARADDR  = ar_addr_q;
  assign s_ARLEN   = ar_len_q;
  assign s_ARSIZE  = ar_size_q;
  assign s_ARBURST = ar_burst_q;
  assign s_ARLOCK  = ar_lock_q;
  assign s_ARCACHE = ar_cache_q;
  assign s_ARPROT  = ar_prot_q;

  assign grant_idx = grant_q;
  assign len_err   = len_err_q;

  assign r_hs   = (state_q == ST_DATA) && s_RVALID && m_RREADY[grant_q];
  assign beat_n = beat_q + 5'd1;

  // Next-state, handshake outputs and payload capture.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
    len_err_d  = len_err_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_lock_d  = ar_lock_q;
    ar_cache_d = ar_cache_q;
    ar_prot_d  = ar_prot_q;
    m_ARREADY  = '0;
    m_RVALID   = '0;
    s_RREADY   = 1'b0;
    s_ARVALID  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reset is asynchronous, so keep ARREADY low while it is held.
        if (win_any && !ARESET) begin
          m_ARREADY  = win_onehot;
          ar_id_d    = m_ARID   [int'(win_idx)*tagbits  +: tagbits];
          ar_addr_d  = m_ARADDR [int'(win_idx)*buswidth +: buswidth];
          ar_len_d   = m_ARLEN  [int'(win_idx)*4 +: 4];
          ar_size_d  = m_ARSIZE [int'(win_idx)*2 +: 2];
          ar_burst_d = m_ARBURST[int'(win_idx)*2 +: 2];
          ar_lock_d  = m_ARLOCK [int'(win_idx)*2 +: 2];
          ar_cache_d = m_ARCACHE[int'(win_idx)*4 +: 4];
          ar_prot_d  = m_ARPROT [int'(win_idx)*3 +: 3];
          grant_d    = win_idx;
          rr_ptr_d   = win_idx;
          beat_d     = '0;
          state_d    = ST_ADDR;
        end
      end

      ST_ADDR: begin
        s_ARVALID = 1'b1;
        if (s_ARREADY) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        m_RVALID[grant_q] = s_RVALID;
        s_RREADY          = m_RREADY[grant_q];
        if (r_hs) begin
          beat_d = beat_n;
          // Flag RLAST on the wrong beat, or the final beat without RLAST.
          if (s_RLAST != (beat_n == burst_beats(ar_len_q))) begin
            len_err_d = 1'b1;
          end
          // Only RLAST closes the burst, whatever ARLEN said.
          if (s_RLAST) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and payload registers with asynchronous reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GW'(NM - 1);
      beat_q     <= '0;
      len_err_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_lock_q  <= '0;
      ar_cache_q <= '0;
      ar_prot_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_q     <= beat_d;
      len_err_q  <= len_err_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_lock_q  <= ar_lock_d;
      ar_cache_q <= ar_cache_d;
      ar_prot_q  <= ar_prot_d;
    end
  end

endmodule
